// File: rtl/dmem_job_sequencer.sv
// Sequencer that owns the data memory port for one downsampling job:
// load host bytes, let the CPU run until it stops, then stream the result region back out.
module dmem_job_sequencer #(
  parameter int          LOAD_LEN    = 16384,
  parameter logic [15:0] DUMP_BASE   = 16'h4000,
  parameter int          DUMP_LEN    = 4096,
  parameter int          RD_LAT      = 1,
  parameter logic [31:0] RUN_TIMEOUT = 32'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wren,
  input  logic        cpu_stop,
  output logic        cpu_run,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wren,
  input  logic [7:0]  mem_q,
  output logic [2:0]  state,
  output logic        busy,
  output logic        done,
  output logic        err_rx,
  output logic        err_tmo
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // LOAD    | writing host bytes to memory from address 0
  // RUN     | CPU owns the memory port, watchdog counting down
  // DUMP_RD | result address presented, waiting for read data
  // DUMP_TX | result byte offered to host, waiting for tx_ready
  // DONE    | job finished (or aborted by watchdog), waiting for start
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    DUMP_RD = 3'd3,
    DUMP_TX = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [16:0] LOAD_END  = 17'(LOAD_LEN);
  localparam logic [16:0] DUMP_LAST = 17'(DUMP_LEN - 1);
  localparam logic [1:0]  LAT_INIT  = 2'(RD_LAT);

  state_t      state_q;
  logic [16:0] cnt_q;
  logic [31:0] wd_q;
  logic [1:0]  lat_q;
  logic [15:0] seq_addr_q;
  logic [7:0]  seq_wdata_q;
  logic        seq_wren_q;
  logic        cpu_run_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        err_rx_q;
  logic        err_tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      lat_q       <= '0;
      seq_addr_q  <= '0;
      seq_wdata_q <= '0;
      seq_wren_q  <= 1'b0;
      cpu_run_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_rx_q    <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      seq_wren_q <= 1'b0;
      // cnt_q == LOAD_END marks the cycle the last byte is on the bus; rx is dropped there too
      if (rx_valid && !(state_q == LOAD && cnt_q != LOAD_END))
        err_rx_q <= 1'b1;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= LOAD;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_rx_q  <= 1'b0;
            err_tmo_q <= 1'b0;
          end
        end
        LOAD: begin
          if (cnt_q == LOAD_END) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            cpu_run_q <= 1'b1;
            wd_q      <= RUN_TIMEOUT;
          end else if (rx_valid) begin
            seq_wren_q  <= 1'b1;
            seq_addr_q  <= cnt_q[15:0];
            seq_wdata_q <= rx_data;
            cnt_q       <= cnt_q + 17'd1;
          end
        end
        RUN: begin
          if (cpu_stop) begin
            state_q    <= DUMP_RD;
            cpu_run_q  <= 1'b0;
            cnt_q      <= '0;
            seq_addr_q <= DUMP_BASE;
            lat_q      <= LAT_INIT;
          end else if (RUN_TIMEOUT != 32'd0 && wd_q == 32'd1) begin
            state_q   <= DONE;
            cpu_run_q <= 1'b0;
            err_tmo_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else if (RUN_TIMEOUT != 32'd0) begin
            wd_q <= wd_q - 32'd1;
          end
        end
        DUMP_RD: begin
          if (lat_q == 2'd0) begin
            tx_data_q  <= mem_q;
            tx_valid_q <= 1'b1;
            state_q    <= DUMP_TX;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        DUMP_TX: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            cnt_q      <= cnt_q + 17'd1;
            if (cnt_q == DUMP_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q    <= DUMP_RD;
              seq_addr_q <= DUMP_BASE + cnt_q[15:0] + 16'd1;
              lat_q      <= LAT_INIT;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // CPU gets the memory port combinationally, but only while in RUN
  assign mem_addr  = (state_q == RUN) ? cpu_addr  : seq_addr_q;
  assign mem_wdata = (state_q == RUN) ? cpu_wdata : seq_wdata_q;
  assign mem_wren  = (state_q == RUN) ? cpu_wren  : seq_wren_q;

  assign state    = state_q;
  assign cpu_run  = cpu_run_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_rx   = err_rx_q;
  assign err_tmo  = err_tmo_q;

endmodule
